// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// seg7_pkg: shared 7-segment widths, active-low glyph table and reader states.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package seg7_pkg;
  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_UNKNOWN = 7'b0110110;

  // Entry n (n = 0..F) lives at [n*SEG_W +: SEG_W]; bit6..bit0 = g..a, active-low.
  localparam logic [16*SEG_W-1:0] GLYPH_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/seg7_pattern_match.sv
//------------------------------------------------------------------------------
// seg7_pattern_match: combinational active-low glyph to {hit, nibble} lookup.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg7_pattern_match
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]    seg,
  output logic                hit,
  output logic [NIBBLE_W-1:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i*SEG_W +: SEG_W]) begin
        hit    = 1'b1;
        nibble = NIBBLE_W'(i);
      end
    end
    if (seg == SEG_UNKNOWN) begin
      hit    = 1'b0;
      nibble = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_reader.sv
//------------------------------------------------------------------------------
// seg7_scan_reader: recovers per-digit hex nibbles from a scanned 7-seg bus.
// Define SEG7_SCAN_READER_ERRCNT_EN to add the err_count output. Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DIGITS-1:0]          an_in,
  input  logic [SEG_W-1:0]               seg_in,
  output logic [NIBBLE_W*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]          frame_bad,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           overrun
`ifdef SEG7_SCAN_READER_ERRCNT_EN
  ,
  output logic [7:0]                     err_count
`endif
);

  localparam int         c_bus_w  = NUM_DIGITS + SEG_W;
  localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);

  logic [c_bus_w-1:0]             r_sync1, r_sync2, r_prev;
  logic [7:0]                     r_cnt, w_cnt_next;
  logic                           w_strobe, w_capture, w_hit, w_seen_full, w_transfer;
  logic [NIBBLE_W-1:0]            w_nibble;
  logic [NUM_DIGITS-1:0]          w_an_act, w_cap_mask, r_seen, r_work_bad;
  logic [NIBBLE_W*NUM_DIGITS-1:0] r_work;
  state_t                         r_state;

  assign w_an_act = ~r_sync2[c_bus_w-1 -: NUM_DIGITS];

  seg7_pattern_match u_match (
    .seg    (r_sync2[SEG_W-1:0]),
    .hit    (w_hit),
    .nibble (w_nibble)
  );

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_sync2 != r_prev)
      w_cnt_next = 8'd1;
    else if (r_cnt != c_stable)
      w_cnt_next = r_cnt + 8'd1;
  end

  // Strobe only on the transition into saturation, so a long hold captures once.
  assign w_strobe    = (w_cnt_next == c_stable) && (r_cnt != c_stable);
  assign w_capture   = w_strobe && $onehot(w_an_act);
  assign w_cap_mask  = w_capture ? w_an_act : '0;
  assign w_seen_full = &r_seen;
  assign w_transfer  = frame_valid && frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {an_in, seg_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work     <= '0;
      r_work_bad <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_mask[i]) begin
          r_work[i*NIBBLE_W +: NIBBLE_W] <= w_hit ? w_nibble : '0;
          r_work_bad[i]                  <= ~w_hit;
        end
      end
    end
  end

`ifdef SEG7_SCAN_READER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (w_capture && !w_hit && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

  // A capture landing on a hand-off edge seeds the next frame's seen mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_seen       <= '0;
      frame_digits <= '0;
      frame_bad    <= '0;
      frame_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_seen_full) begin
            frame_digits <= r_work;
            frame_bad    <= r_work_bad;
            frame_valid  <= 1'b1;
            r_seen       <= w_cap_mask;
            r_state      <= HOLD;
          end else begin
            r_seen <= r_seen | w_cap_mask;
          end
        end
        HOLD: begin
          if (w_transfer) begin
            frame_valid <= 1'b0;
            r_seen      <= r_seen | w_cap_mask;
            r_state     <= COLLECT;
          end else if (w_seen_full) begin
            overrun <= 1'b1;
            r_seen  <= w_cap_mask;
          end else begin
            r_seen <= r_seen | w_cap_mask;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
//------------------------------------------------------------------------------
// tb_seg7_scan_reader: scoreboard bench with a run-length reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_scan_reader;
  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an_in = 4'hF;
  logic [6:0]  seg_in = 7'h7F;
  logic [15:0] frame_digits;
  logic [3:0]  frame_bad;
  logic        frame_valid;
  logic        frame_ready = 1'b1;
  logic        overrun;
`ifdef SEG7_SCAN_READER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .frame_digits (frame_digits),
    .frame_bad    (frame_bad),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .overrun      (overrun)
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] UNK = 7'b0110110;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
  } frame_t;
  frame_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = 0, last_apply_cyc = 0;
  bit prev_valid = 1'b0;

  // Reference model: a pin value held for SC cycles with one anode low is a capture.
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  int          m_len = 0;
  logic [15:0] m_work = '0;
  logic [3:0]  m_bad = '0, m_seen = '0;
  bit          m_pending = 1'b0, m_ovr = 1'b0;
  int          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_capture();
    int idx;
    bit hit;
    logic [3:0] nib;
    if ($countones(~m_an) != 1) return;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!m_an[i]) idx = i;
    hit = 1'b0;
    nib = '0;
    for (int k = 0; k < 16; k++) if (glyph_tab[k] == m_seg) begin hit = 1'b1; nib = k[3:0]; end
    m_work[idx*4 +: 4] = hit ? nib : 4'h0;
    m_bad[idx] = !hit;
    if (!hit && m_err < 255) m_err++;
    m_seen[idx] = 1'b1;
    if (&m_seen) begin
      m_seen = '0;
      if (m_pending) m_ovr = 1'b1;
      else begin
        exp_q.push_back('{d: m_work, b: m_bad});
        m_pending = !frame_ready;
      end
    end
  endtask

  task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int n);
    if (an !== m_an || seg !== m_seg) begin
      m_an = an;
      m_seg = seg;
      m_len = 0;
      last_apply_cyc = cyc;
    end
    an_in = an;
    seg_in = seg;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      m_len++;
      if (m_len == SC) model_capture();
    end
  endtask

  task automatic idle(input int n);
    apply(4'hF, 7'h7F, n);
  endtask

  task automatic scan(input logic [15:0] digs, input int hold);
    logic [3:0] an;
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
      apply(an, glyph_tab[digs[i*4 +: 4]], hold);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    frame_t e;
    if (frame_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = frame_valid;
    if (!rst && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%h/%b required=none", frame_digits, frame_bad);
      end else begin
        e = exp_q.pop_front();
        check("frame_digits", {16'h0, frame_digits}, {16'h0, e.d});
        check("frame_bad", {28'h0, frame_bad}, {28'h0, e.b});
      end
    end
  end

  initial begin
    int d3, r, hold;
    logic [3:0] an;
    logic [6:0] seg;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, frame_valid}, 0);
    check("rst_digits", {16'h0, frame_digits}, 0);
    check("rst_bad", {28'h0, frame_bad}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    check("rst_err_count", {24'h0, err_count}, 0);
`endif
    rst = 1'b0;
    idle(6);

    scan(16'h1234, 8);
    d3 = last_apply_cyc;
    idle(12);
    check("latency", rise_cyc - d3, 7);
    check("digits_1234", {16'h0, frame_digits}, 32'h1234);
    check("bad_1234", {28'h0, frame_bad}, 0);
    check("valid_after_xfer", {31'h0, frame_valid}, 0);

    apply(4'b1110, glyph_tab[8], 3);
    idle(10);
    apply(4'b1101, glyph_tab[9], 8);
    apply(4'b1011, glyph_tab[10], 8);
    apply(4'b0111, glyph_tab[11], 8);
    idle(12);
    check("glitch_no_frame", {16'h0, frame_digits}, 32'h1234);
    apply(4'b1110, glyph_tab[7], 8);
    idle(12);
    check("glitch_then_frame", {16'h0, frame_digits}, 32'hBA97);

    apply(4'b1110, glyph_tab[1], 8);
    apply(4'b1101, glyph_tab[2], 8);
    apply(4'b1011, UNK, 8);
    apply(4'b0111, glyph_tab[3], 8);
    idle(12);
    check("bad_mask", {28'h0, frame_bad}, 32'h4);
    check("bad_nibble", {28'h0, frame_digits[11:8]}, 0);
    check("bad_digits", {16'h0, frame_digits}, 32'h3021);
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    check("err_count_one", {24'h0, err_count}, 1);
`endif

    apply(4'b1100, glyph_tab[5], 20);
    apply(4'b1011, glyph_tab[6], 8);
    apply(4'b0111, glyph_tab[7], 8);
    idle(12);
    check("multi_no_frame", {16'h0, frame_digits}, 32'h3021);
    apply(4'b1110, glyph_tab[8], 8);
    apply(4'b1101, glyph_tab[9], 8);
    idle(12);
    check("multi_then_frame", {16'h0, frame_digits}, 32'h7698);

    frame_ready = 1'b0;
    scan(16'h5678, 8);
    idle(12);
    check("hold_valid", {31'h0, frame_valid}, 1);
    scan(16'h9ABC, 8);
    scan(16'hDEF0, 8);
    idle(12);
    check("overrun_set", {31'h0, overrun}, 1);
    check("overrun_valid", {31'h0, frame_valid}, 1);
    check("overrun_keeps_oldest", {16'h0, frame_digits}, 32'h5678);
    frame_ready = 1'b1;
    m_pending = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drop", {31'h0, frame_valid}, 0);
    check("overrun_sticky", {31'h0, overrun}, 1);
    idle(4);

    frame_ready = 1'b0;
    scan(16'h2468, 8);
    idle(12);
    check("pre_rst_valid", {31'h0, frame_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, frame_valid}, 0);
    check("async_rst_digits", {16'h0, frame_digits}, 0);
    check("async_rst_bad", {28'h0, frame_bad}, 0);
    check("async_rst_overrun", {31'h0, overrun}, 0);
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    check("async_rst_err_count", {24'h0, err_count}, 0);
`endif
    exp_q.delete();
    m_work = '0;
    m_bad = '0;
    m_seen = '0;
    m_pending = 1'b0;
    m_ovr = 1'b0;
    m_err = 0;
    m_len = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_ready = 1'b1;
    idle(4);
    scan(16'hCAFE, 8);
    idle(12);
    check("post_rst_frame", {16'h0, frame_digits}, 32'hCAFE);
    check("post_rst_valid", {31'h0, frame_valid}, 0);

    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      an = ~(4'b0001 << $urandom_range(0, 3));
      seg = glyph_tab[$urandom_range(0, 15)];
      case (r)
        6: seg = 7'($urandom_range(0, 127));
        7: begin an = 4'hF; seg = 7'h7F; end
        8: an = 4'($urandom_range(0, 15));
        9: seg = UNK;
        default: ;
      endcase
      apply(an, seg, hold);
    end
    idle(20);
    check("queue_drained", exp_q.size(), 0);
    check("final_overrun", {31'h0, overrun}, {31'h0, m_ovr});
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    check("final_err_count", {24'h0, err_count}, m_err);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
